// File: rtl/isa_pipe_tracker_pkg.sv
// Shared types and helpers for the shadow-pipeline tracker.
// Record types are sized for the default RV12 configuration that checkers bind against.
package isa_trk_pkg;

    localparam int XLEN_D  = 32;
    localparam int ILEN_D  = 32;
    localparam int SEQ_W_D = 16;

    typedef struct packed {
        logic              valid;
        logic [XLEN_D-1:0] pc;
        logic [ILEN_D-1:0] insn;
    } stage_rec_t;

    typedef struct packed {
        logic [XLEN_D-1:0]  pc;
        logic [ILEN_D-1:0]  insn;
        logic [SEQ_W_D-1:0] seq;
    } retire_rec_t;

    // Low two PC bits kept on capture: bit 1 survives only with compressed instructions.
    function automatic logic [1:0] pc_low_mask(input bit c_ext);
        return c_ext ? 2'b10 : 2'b00;
    endfunction

endpackage

// File: rtl/isa_pipe_tracker_if.sv
// Bundle between the core-side driver and the tracker: fetch/stall/flush in,
// retire stream and per-stage shadow state out.
interface isa_pipe_tracker_if #(
    parameter int XLEN   = 32,
    parameter int ILEN   = 32,
    parameter int STAGES = 6,
    parameter int SEQ_W  = 16
);
    logic                     fetch_valid_i;
    logic [XLEN-1:0]          fetch_pc_i;
    logic [ILEN-1:0]          fetch_insn_i;
    logic [STAGES-1:0]        stall_i;
    logic [STAGES-1:0]        flush_i;
    logic                     retire_ready_i;
    logic                     retire_valid_o;
    logic [XLEN-1:0]          retire_pc_o;
    logic [ILEN-1:0]          retire_insn_o;
    logic [SEQ_W-1:0]         retire_seq_o;
    logic [STAGES-1:0]        stage_valid_o;
    logic [STAGES*XLEN-1:0]   stage_pc_o;
    logic [STAGES*ILEN-1:0]   stage_insn_o;
    logic                     overflow_o;

    modport master (
        output fetch_valid_i, fetch_pc_i, fetch_insn_i, stall_i, flush_i, retire_ready_i,
        input  retire_valid_o, retire_pc_o, retire_insn_o, retire_seq_o,
               stage_valid_o, stage_pc_o, stage_insn_o, overflow_o
    );

    modport slave (
        input  fetch_valid_i, fetch_pc_i, fetch_insn_i, stall_i, flush_i, retire_ready_i,
        output retire_valid_o, retire_pc_o, retire_insn_o, retire_seq_o,
               stage_valid_o, stage_pc_o, stage_insn_o, overflow_o
    );
endinterface

// File: rtl/isa_pipe_tracker_fifo.sv
// Retire queue: circular buffer with occupancy counter and a registered head word.
// A push into an empty queue is visible at the head right after the same edge.
module isa_trk_fifo #(
    parameter int               DEPTH = 4,
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= INIT;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
            // The incoming word becomes the head only if nothing older remains behind it.
            if (do_push && (empty || (do_pop && count == ONE_C)))
                head <= push_data;
            else if (do_pop && count > ONE_C)
                head <= mem[rd_ptr + 1'b1];
        end
    end
endmodule

// File: rtl/isa_pipe_tracker.sv
// Shadow pipeline for RV12 checkers: tracks valid/pc/insn per stage under the core's
// stall and flush vectors and emits a sequence-numbered retirement stream.
module isa_pipe_tracker
    import isa_trk_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              STAGES   = 6,
    parameter logic [XLEN-1:0] PC_INIT  = 32'h200,
    parameter logic [ILEN-1:0] NOP      = 32'h13,
    parameter int              C_EXT    = 0,
    parameter int              SEQ_W    = 16,
    parameter int              RQ_DEPTH = 4
) (
    input logic                clk,
    input logic                rst_n,
    isa_pipe_tracker_if.slave  trk
);
    localparam int RW = XLEN + ILEN + SEQ_W;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] insn;
    } stg_t;

    stg_t              stg_q [STAGES];
    logic [STAGES-1:0] hold;
    logic [XLEN-1:0]   fetch_pc_al;
    logic [SEQ_W-1:0]  seq_cnt;
    logic              retire_push, rq_pop, rq_full, rq_empty, ovf_q;
    logic [RW-1:0]     rq_head;

    assign fetch_pc_al = trk.fetch_pc_i & {{(XLEN-2){1'b1}}, pc_low_mask(C_EXT != 0)};

    // A stalled stage freezes itself and everything younger.
    for (genvar s = 0; s < STAGES; s++) begin : g_hold
        assign hold[s] = |trk.stall_i[STAGES-1:s];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++)
                stg_q[s] <= '{valid: 1'b0, pc: PC_INIT, insn: NOP};
        end else begin
            if (!hold[0])
                stg_q[0] <= '{valid: trk.fetch_valid_i, pc: fetch_pc_al, insn: trk.fetch_insn_i};
            if (trk.flush_i[0])
                stg_q[0].valid <= 1'b0;
            for (int s = 1; s < STAGES; s++) begin
                if (!hold[s]) begin
                    if (!hold[s-1]) stg_q[s] <= stg_q[s-1];
                    else            stg_q[s].valid <= 1'b0;
                end
                if (trk.flush_i[s])
                    stg_q[s].valid <= 1'b0;
            end
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_out
        assign trk.stage_valid_o[s]                = stg_q[s].valid;
        assign trk.stage_pc_o[s*XLEN +: XLEN]      = stg_q[s].pc;
        assign trk.stage_insn_o[s*ILEN +: ILEN]    = stg_q[s].insn;
    end

    // A last-stage flush does not cancel this: the leaving instruction has completed.
    assign retire_push = stg_q[STAGES-1].valid & ~hold[STAGES-1];
    assign rq_pop      = ~rq_empty & trk.retire_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_cnt <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (retire_push)
                seq_cnt <= seq_cnt + 1'b1;
            if (retire_push && rq_full && !rq_pop)
                ovf_q <= 1'b1;
        end
    end

    isa_trk_fifo #(
        .DEPTH (RQ_DEPTH),
        .WIDTH (RW),
        .INIT  ({PC_INIT, NOP, {SEQ_W{1'b0}}})
    ) u_rq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (retire_push),
        .push_data ({stg_q[STAGES-1].pc, stg_q[STAGES-1].insn, seq_cnt}),
        .pop       (rq_pop),
        .full      (rq_full),
        .empty     (rq_empty),
        .head      (rq_head)
    );

    assign trk.retire_valid_o = ~rq_empty;
    assign {trk.retire_pc_o, trk.retire_insn_o, trk.retire_seq_o} = rq_head;
    assign trk.overflow_o     = ovf_q;
endmodule

// File: tb/tb_isa_pipe_tracker.sv
// Directed bench for isa_pipe_tracker: STAGES=6, RQ_DEPTH=4, SEQ_W=4 so sequence wrap is reachable.
module tb_isa_pipe_tracker;
    localparam int XLEN = 32, ILEN = 32, STAGES = 6, SEQ_W = 4, RQ_DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;

    always #5 clk = ~clk;

    isa_pipe_tracker_if #(.XLEN(XLEN), .ILEN(ILEN), .STAGES(STAGES), .SEQ_W(SEQ_W)) bus ();

    isa_pipe_tracker #(
        .XLEN(XLEN), .ILEN(ILEN), .STAGES(STAGES), .PC_INIT(32'h200), .NOP(32'h13),
        .C_EXT(0), .SEQ_W(SEQ_W), .RQ_DEPTH(RQ_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .trk   (bus)
    );

    function automatic logic [31:0] insn_of(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] insn);
        bus.fetch_valid_i = 1'b1;
        bus.fetch_pc_i    = pc;
        bus.fetch_insn_i  = insn;
        step();
    endtask

    // Waits (bounded) for a head, checks it, then advances one edge so ready=1 pops it.
    task automatic expect_retire(input string tag, input logic [31:0] pc, input logic [3:0] seq);
        int n = 0;
        while (bus.retire_valid_o !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({tag, ".valid"}, 256'(bus.retire_valid_o), 256'(1'b1));
        chk({tag, ".pc"},    256'(bus.retire_pc_o),    256'(pc));
        chk({tag, ".insn"},  256'(bus.retire_insn_o),  256'(insn_of(pc)));
        chk({tag, ".seq"},   256'(bus.retire_seq_o),   256'(seq));
        step();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".svalid"}, 256'(bus.stage_valid_o),  256'(6'b0));
        chk({tag, ".spc"},    256'(bus.stage_pc_o),     256'({6{32'h200}}));
        chk({tag, ".sinsn"},  256'(bus.stage_insn_o),   256'({6{32'h13}}));
        chk({tag, ".rvalid"}, 256'(bus.retire_valid_o), 256'(1'b0));
        chk({tag, ".rpc"},    256'(bus.retire_pc_o),    256'(32'h200));
        chk({tag, ".rinsn"},  256'(bus.retire_insn_o),  256'(32'h13));
        chk({tag, ".rseq"},   256'(bus.retire_seq_o),   256'(4'd0));
        chk({tag, ".ovf"},    256'(bus.overflow_o),     256'(1'b0));
    endtask

    initial begin
        bus.fetch_valid_i  = 1'b0;
        bus.fetch_pc_i     = '0;
        bus.fetch_insn_i   = '0;
        bus.stall_i        = '0;
        bus.flush_i        = '0;
        bus.retire_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_state("rst");
        rst_n = 1'b1;

        // Straight-line run; third PC is unaligned and must be captured as 0x208.
        fetch(32'h200, insn_of(32'h200));
        fetch(32'h204, insn_of(32'h204));
        fetch(32'h20B, insn_of(32'h208));
        chk("line.svalid", 256'(bus.stage_valid_o), 256'(6'b000111));
        chk("line.align",  256'(bus.stage_pc_o[31:0]), 256'(32'h208));
        chk("line.s2pc",   256'(bus.stage_pc_o[95:64]), 256'(32'h200));
        bus.fetch_valid_i = 1'b0;
        repeat (3) step();
        chk("line.s5full", 256'(bus.stage_valid_o), 256'(6'b111000));
        chk("line.early",  256'(bus.retire_valid_o), 256'(1'b0));
        step();
        chk("line0.valid", 256'(bus.retire_valid_o), 256'(1'b1));
        chk("line0.pc",    256'(bus.retire_pc_o), 256'(32'h200));
        chk("line0.seq",   256'(bus.retire_seq_o), 256'(4'd0));
        step();
        chk("line1.pc",    256'(bus.retire_pc_o), 256'(32'h204));
        chk("line1.seq",   256'(bus.retire_seq_o), 256'(4'd1));
        step();
        chk("line2.pc",    256'(bus.retire_pc_o), 256'(32'h208));
        chk("line2.seq",   256'(bus.retire_seq_o), 256'(4'd2));
        step();
        chk("line.drain",  256'(bus.retire_valid_o), 256'(1'b0));
        chk("line.hold",   256'(bus.retire_pc_o), 256'(32'h208));

        // Stall stage 2 for three edges with stages 0-3 occupied.
        fetch(32'h300, insn_of(32'h300));
        fetch(32'h304, insn_of(32'h304));
        fetch(32'h308, insn_of(32'h308));
        fetch(32'h30C, insn_of(32'h30C));
        bus.stall_i       = 6'b000100;
        bus.fetch_valid_i = 1'b1;
        bus.fetch_pc_i    = 32'h310;
        bus.fetch_insn_i  = insn_of(32'h310);
        repeat (3) step();
        chk("stall.svalid", 256'(bus.stage_valid_o), 256'(6'b000111));
        chk("stall.s0pc",   256'(bus.stage_pc_o[31:0]), 256'(32'h30C));
        chk("stall.s2pc",   256'(bus.stage_pc_o[95:64]), 256'(32'h304));
        chk("stall.s3pc",   256'(bus.stage_pc_o[127:96]), 256'(32'h300));
        bus.stall_i       = '0;
        bus.fetch_valid_i = 1'b0;
        expect_retire("stall0", 32'h300, 4'd3);
        expect_retire("stall1", 32'h304, 4'd4);
        expect_retire("stall2", 32'h308, 4'd5);
        expect_retire("stall3", 32'h30C, 4'd6);

        // Flush stages 0-1: 0x410 (entering stage 1) and 0x414 (entering stage 0) die.
        fetch(32'h400, insn_of(32'h400));
        fetch(32'h404, insn_of(32'h404));
        fetch(32'h410, insn_of(32'h410));
        bus.flush_i = 6'b000011;
        fetch(32'h414, insn_of(32'h414));
        bus.flush_i = '0;
        chk("flush.svalid", 256'(bus.stage_valid_o), 256'(6'b001100));
        chk("flush.s1pc",   256'(bus.stage_pc_o[63:32]), 256'(32'h410));
        fetch(32'h418, insn_of(32'h418));
        bus.fetch_valid_i = 1'b0;
        expect_retire("flush0", 32'h400, 4'd7);
        expect_retire("flush1", 32'h404, 4'd8);
        for (int n = 0; n < 20 && bus.stage_valid_o[5] !== 1'b1; n++) step();
        chk("lastflush.s5", 256'(bus.stage_valid_o[5]), 256'(1'b1));
        bus.flush_i = 6'b100000;
        step();
        bus.flush_i = '0;
        expect_retire("lastflush", 32'h418, 4'd9);

        // Overflow: five retirements into a four-deep queue with no consumer.
        bus.retire_ready_i = 1'b0;
        fetch(32'h500, insn_of(32'h500));
        fetch(32'h504, insn_of(32'h504));
        fetch(32'h508, insn_of(32'h508));
        fetch(32'h50C, insn_of(32'h50C));
        fetch(32'h510, insn_of(32'h510));
        bus.fetch_valid_i = 1'b0;
        repeat (8) step();
        chk("ovf.valid", 256'(bus.retire_valid_o), 256'(1'b1));
        chk("ovf.pc",    256'(bus.retire_pc_o), 256'(32'h500));
        chk("ovf.seq",   256'(bus.retire_seq_o), 256'(4'd10));
        chk("ovf.flag",  256'(bus.overflow_o), 256'(1'b1));
        bus.retire_ready_i = 1'b1;
        expect_retire("ovf0", 32'h500, 4'd10);
        expect_retire("ovf1", 32'h504, 4'd11);
        expect_retire("ovf2", 32'h508, 4'd12);
        expect_retire("ovf3", 32'h50C, 4'd13);
        chk("ovf.empty",  256'(bus.retire_valid_o), 256'(1'b0));
        chk("ovf.sticky", 256'(bus.overflow_o), 256'(1'b1));
        fetch(32'h520, insn_of(32'h520));
        bus.fetch_valid_i = 1'b0;
        expect_retire("gap", 32'h520, 4'd15);

        // Sequence wrap 15 -> 0 -> 1.
        fetch(32'h600, insn_of(32'h600));
        fetch(32'h604, insn_of(32'h604));
        bus.fetch_valid_i = 1'b0;
        expect_retire("wrap0", 32'h600, 4'd0);
        expect_retire("wrap1", 32'h604, 4'd1);

        // Mid-run reset with two queued and three in flight.
        bus.retire_ready_i = 1'b0;
        fetch(32'h700, insn_of(32'h700));
        fetch(32'h704, insn_of(32'h704));
        fetch(32'h708, insn_of(32'h708));
        fetch(32'h70C, insn_of(32'h70C));
        fetch(32'h710, insn_of(32'h710));
        bus.fetch_valid_i = 1'b0;
        repeat (3) step();
        chk("pre.svalid", 256'(bus.stage_valid_o), 256'(6'b111000));
        chk("pre.pc",     256'(bus.retire_pc_o), 256'(32'h700));
        chk("pre.seq",    256'(bus.retire_seq_o), 256'(4'd2));
        #2 rst_n = 1'b0;
        #1 chk_reset_state("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        bus.retire_ready_i = 1'b1;
        fetch(32'h800, insn_of(32'h800));
        bus.fetch_valid_i = 1'b0;
        expect_retire("post", 32'h800, 4'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
